// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared state encodings, default width and counter sizing for div_iter
package div_iter_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic int div_cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic                  q_o
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] divisor_ext;

  assign shifted     = {rem_i, bit_i};
  assign divisor_ext = {2'b00, divisor_i};
  assign q_o         = (shifted >= divisor_ext);
  // Partial remainder stays below the divisor, so the top shifted bit is always dropped safely.
  assign rem_o = q_o ? (DATA_WIDTH+1)'(shifted - divisor_ext)
                     : (DATA_WIDTH+1)'(shifted);

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative signed/unsigned restoring divider; DIV_FLUSH_EN adds a flush input
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
`ifdef DIV_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  div_by_zero
);

  localparam int CW = div_cnt_width(DATA_WIDTH);

  div_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rmd_q, rmd_d;
  logic                  dbz_q, dbz_d;

  logic                  sa, sb;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [DATA_WIDTH:0]   step_rem;
  logic                  step_q;
  logic [DATA_WIDTH-1:0] q_next;
  logic [DATA_WIDTH-1:0] r_final;
  logic                  flush_act;

`ifdef DIV_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  assign in_ready    = (state_q == DIV_IDLE) && !flush_act;
  assign out_valid   = (state_q == DIV_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

  assign sa    = in_signed & dividend[DATA_WIDTH-1];
  assign sb    = in_signed & divisor[DATA_WIDTH-1];
  assign mag_a = sa ? (~dividend + 1'b1) : dividend;
  assign mag_b = sb ? (~divisor + 1'b1) : divisor;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DATA_WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // dq_q holds the dividend bits still to consume; freed low bits collect quotient bits.
  assign q_next  = {dq_q[DATA_WIDTH-2:0], step_q};
  assign r_final = step_rem[DATA_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (in_valid && in_ready) begin
          negq_d = sa ^ sb;
          negr_d = sa;
          dvs_d  = mag_b;
          rem_d  = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            dq_d    = dividend;
            state_d = DIV_ZERO;
          end else begin
            dq_d    = mag_a;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        dq_d  = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          quo_d   = (negq_q && (q_next != '0)) ? (~q_next + 1'b1) : q_next;
          rmd_d   = negr_q ? (~r_final + 1'b1) : r_final;
          dbz_d   = 1'b0;
          state_d = DIV_DONE;
        end
      end
      DIV_ZERO: begin
        quo_d   = '1;
        rmd_d   = dq_q;
        dbz_d   = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush_act && (state_q != DIV_IDLE)) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule
